// File: rtl/cnn_mem_pkg.sv
// Shared widths, pixel/address types and layer-size helper for the feature-map memory.
package cnn_mem_pkg;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1024;

    typedef logic signed [DW-1:0] pixel_t;
    typedef logic [AW-1:0]        addr_t;

    function automatic int unsigned fmap_words(input int unsigned h, input int unsigned w);
        return h * w;
    endfunction

endpackage

// File: rtl/fmap_bank_3r1w.sv
// One feature-map bank: three synchronous range-checked read ports, one write port,
// read-before-write on address collisions.
module fmap_bank_3r1w
    import cnn_mem_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr0,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2
);

    logic [DW-1:0] mem [DEPTH];

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < (AW+1)'(DEPTH);
    endfunction

    always_ff @(posedge clk) begin
        if (we && in_range(waddr)) begin
            mem[waddr] <= wdata;
        end
    end

    // Nonblocking write above means these always sample the pre-write contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata0 <= '0;
            rdata1 <= '0;
            rdata2 <= '0;
        end else begin
            rdata0 <= in_range(raddr0) ? mem[raddr0] : '0;
            rdata1 <= in_range(raddr1) ? mem[raddr1] : '0;
            rdata2 <= in_range(raddr2) ? mem[raddr2] : '0;
        end
    end

endmodule

// File: rtl/fmap_pingpong_mem.sv
// Ping-pong feature-map memory: engine reads/host writes the read bank, engine stores/host
// reads the write bank; banks swap on layer_done.
module fmap_pingpong_mem
    import cnn_mem_pkg::*;
#(
    parameter int unsigned OUT_H = 26,
    parameter int unsigned OUT_W = 26
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rd_addr1,
    input  logic [AW-1:0] rd_addr2,
    output logic [DW-1:0] rd_data1,
    output logic [DW-1:0] rd_data2,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          layer_done,
    input  logic          host_we,
    input  logic [AW-1:0] host_waddr,
    input  logic [DW-1:0] host_wdata,
    input  logic [AW-1:0] host_raddr,
    output logic [DW-1:0] host_rdata,
    output logic          bank_sel,
    output logic [AW-1:0] wr_count,
    output logic          err_oob,
    output logic          err_short
);

    localparam int unsigned   N_WORDS   = fmap_words(OUT_H, OUT_W);
    localparam logic [AW-1:0] N_WORDS_A = AW'(N_WORDS);
    localparam logic [AW-1:0] CNT_MAX   = '1;

    logic          eng_ok;
    logic [AW-1:0] count_nxt;
    logic          rd_sel_q;
    logic          b0_we, b1_we;
    logic [AW-1:0] b0_waddr, b1_waddr;
    logic [DW-1:0] b0_wdata, b1_wdata;
    logic [DW-1:0] b0_r0, b0_r1, b0_r2;
    logic [DW-1:0] b1_r0, b1_r1, b1_r2;

    assign eng_ok    = wr_en && (wr_addr < N_WORDS_A);
    assign count_nxt = wr_count + AW'(eng_ok && (wr_count != CNT_MAX));

    // Engine stores go to the write bank, host stores to the read bank; both gated during reset.
    assign b0_we    = !rst && (bank_sel ? eng_ok : host_we);
    assign b0_waddr = bank_sel ? wr_addr : host_waddr;
    assign b0_wdata = bank_sel ? wr_data : host_wdata;
    assign b1_we    = !rst && (bank_sel ? host_we : eng_ok);
    assign b1_waddr = bank_sel ? host_waddr : wr_addr;
    assign b1_wdata = bank_sel ? host_wdata : wr_data;

    fmap_bank_3r1w u_bank0 (
        .clk    (clk),
        .rst    (rst),
        .we     (b0_we),
        .waddr  (b0_waddr),
        .wdata  (b0_wdata),
        .raddr0 (rd_addr1),
        .raddr1 (rd_addr2),
        .raddr2 (host_raddr),
        .rdata0 (b0_r0),
        .rdata1 (b0_r1),
        .rdata2 (b0_r2)
    );

    fmap_bank_3r1w u_bank1 (
        .clk    (clk),
        .rst    (rst),
        .we     (b1_we),
        .waddr  (b1_waddr),
        .wdata  (b1_wdata),
        .raddr0 (rd_addr1),
        .raddr1 (rd_addr2),
        .raddr2 (host_raddr),
        .rdata0 (b1_r0),
        .rdata1 (b1_r1),
        .rdata2 (b1_r2)
    );

    // Select captured with the address so a read issued on a swap edge uses the old bank.
    assign rd_data1   = rd_sel_q ? b1_r0 : b0_r0;
    assign rd_data2   = rd_sel_q ? b1_r1 : b0_r1;
    assign host_rdata = rd_sel_q ? b0_r2 : b1_r2;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sel_q  <= 1'b0;
            bank_sel  <= 1'b0;
            wr_count  <= '0;
            err_oob   <= 1'b0;
            err_short <= 1'b0;
        end else begin
            rd_sel_q <= bank_sel;
            if (wr_en && !eng_ok) begin
                err_oob <= 1'b1;
            end
            if (layer_done) begin
                bank_sel <= ~bank_sel;
                wr_count <= '0;
                if (count_nxt != N_WORDS_A) begin
                    err_short <= 1'b1;
                end
            end else begin
                wr_count <= count_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fmap_pingpong_mem.sv
// Directed bench for fmap_pingpong_mem: read-vector table plus layer/swap/error/collision sequences.
module tb_fmap_pingpong_mem;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] rd_addr1, rd_addr2, wr_addr, host_waddr, host_raddr;
    logic [7:0] rd_data1, rd_data2, wr_data, host_wdata, host_rdata;
    logic       wr_en, layer_done, host_we;
    logic       bank_sel, err_oob, err_short;
    logic [9:0] wr_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0] a1;
        logic [9:0] a2;
        int         e1;
        int         e2;
    } rd_vec_t;

    rd_vec_t vecs [6];

    always #5 clk = ~clk;

    fmap_pingpong_mem dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .rd_data1   (rd_data1),
        .rd_data2   (rd_data2),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .layer_done (layer_done),
        .host_we    (host_we),
        .host_waddr (host_waddr),
        .host_wdata (host_wdata),
        .host_raddr (host_raddr),
        .host_rdata (host_rdata),
        .bank_sel   (bank_sel),
        .wr_count   (wr_count),
        .err_oob    (err_oob),
        .err_short  (err_short)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic store(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = 10'(a);
        wr_data = 8'(d);
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{10'd29,  10'd30,  29,  30};
        vecs[1] = '{10'd0,   10'd783, 0,   15};
        vecs[2] = '{10'd127, 10'd128, 127, 0};
        vecs[3] = '{10'd200, 10'd200, 72,  72};
        vecs[4] = '{10'd500, 10'd255, 116, 127};
        vecs[5] = '{10'd641, 10'd1,   1,   1};

        rst = 1'b1; wr_en = 1'b0; layer_done = 1'b0; host_we = 1'b0;
        rd_addr1 = '0; rd_addr2 = '0; wr_addr = '0; wr_data = '0;
        host_waddr = '0; host_wdata = '0; host_raddr = '0;

        // T1 reset
        tick(); tick();
        check("rst_rd_data1", int'(rd_data1), 0);
        check("rst_rd_data2", int'(rd_data2), 0);
        check("rst_host_rdata", int'(host_rdata), 0);
        check("rst_bank_sel", int'(bank_sel), 0);
        check("rst_wr_count", int'(wr_count), 0);
        check("rst_err_oob", int'(err_oob), 0);
        check("rst_err_short", int'(err_short), 0);
        rst = 1'b0;

        // T2 host preload of read bank, then table of engine read pairs
        for (int i = 0; i < 784; i++) begin
            host_we = 1'b1; host_waddr = 10'(i); host_wdata = 8'(i % 128);
            tick();
        end
        host_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rd_addr1 = vecs[i].a1;
            rd_addr2 = vecs[i].a2;
            tick();
            check($sformatf("vec%0d_rd1", i), int'($signed(rd_data1)), vecs[i].e1);
            check($sformatf("vec%0d_rd2", i), int'($signed(rd_data2)), vecs[i].e2);
        end

        // T3 full layer into bank 1
        for (int i = 0; i < 676; i++) store(i, -(i % 100));
        check("t3_count_pre", int'(wr_count), 676);
        host_raddr = 10'd5;
        tick();
        check("t3_host_rd5", int'($signed(host_rdata)), -5);
        layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
        check("t3_bank_sel", int'(bank_sel), 1);
        check("t3_count_post", int'(wr_count), 0);
        check("t3_err_short", int'(err_short), 0);
        check("t3_err_oob", int'(err_oob), 0);
        rd_addr1 = 10'd5; rd_addr2 = 10'd99; host_raddr = 10'd29;
        tick();
        check("t3_rd5", int'($signed(rd_data1)), -5);
        check("t3_rd99", int'($signed(rd_data2)), -99);
        check("t3_host_rd29", int'($signed(host_rdata)), 29);

        // T4 last store, swap and engine read all on one edge
        for (int i = 0; i < 675; i++) store(i, i % 50);
        check("t4_count_pre", int'(wr_count), 675);
        wr_en = 1'b1; wr_addr = 10'd675; wr_data = 8'd7;
        layer_done = 1'b1; rd_addr1 = 10'd675; rd_addr2 = 10'd100;
        tick();
        wr_en = 1'b0; layer_done = 1'b0;
        check("t4_old_bank_rd", int'($signed(rd_data1)), -75);
        check("t4_old_bank_rd100", int'($signed(rd_data2)), 0);
        check("t4_err_short", int'(err_short), 0);
        check("t4_bank_sel", int'(bank_sel), 0);
        check("t4_count_post", int'(wr_count), 0);
        rd_addr2 = 10'd49;
        tick();
        check("t4_new_bank_rd675", int'($signed(rd_data1)), 7);
        check("t4_new_bank_rd49", int'($signed(rd_data2)), 49);

        // T6 host read vs engine store, then host write vs engine read (old data wins)
        host_raddr = 10'd10;
        wr_en = 1'b1; wr_addr = 10'd10; wr_data = 8'd55;
        tick();
        wr_en = 1'b0;
        check("t6_host_old", int'($signed(host_rdata)), -10);
        tick();
        check("t6_host_new", int'($signed(host_rdata)), 55);
        host_we = 1'b1; host_waddr = 10'd20; host_wdata = 8'd99; rd_addr1 = 10'd20;
        tick();
        host_we = 1'b0;
        check("t6_eng_old", int'($signed(rd_data1)), 20);
        tick();
        check("t6_eng_new", int'($signed(rd_data1)), 99);

        // T5 out-of-range store, then short layer
        check("t5_count_before", int'(wr_count), 1);
        store(676, 1);
        check("t5_err_oob", int'(err_oob), 1);
        check("t5_count_oob", int'(wr_count), 1);
        for (int i = 100; i < 199; i++) store(i, 3);
        check("t5_count_100", int'(wr_count), 100);
        layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
        check("t5_err_short", int'(err_short), 1);
        check("t5_bank_sel", int'(bank_sel), 1);
        tick(); tick(); tick();
        check("t5_oob_sticky", int'(err_oob), 1);
        check("t5_short_sticky", int'(err_short), 1);

        // Reset mid-operation: store in reset cycle dropped, memory survives
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 10'd10; wr_data = 8'd1;
        tick();
        wr_en = 1'b0;
        rst = 1'b0;
        check("rst2_bank_sel", int'(bank_sel), 0);
        check("rst2_err_oob", int'(err_oob), 0);
        check("rst2_err_short", int'(err_short), 0);
        check("rst2_wr_count", int'(wr_count), 0);
        rd_addr1 = 10'd20; host_raddr = 10'd10;
        tick();
        check("rst2_keep_rd20", int'($signed(rd_data1)), 99);
        check("rst2_keep_host10", int'($signed(host_rdata)), 55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
